// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, local instruction memory, stall/redirect handling.
// Optional FETCH_PERF_CNT_EN adds perf_fetched and perf_stall_cycles counters.
module inst_fetch #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   inst,
  output logic [31:0]   inst_pc,
  output logic          inst_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]   perf_fetched,
  output logic [31:0]   perf_stall_cycles,
`endif
  output logic          done
);

  localparam logic [31:0] PC_END = 32'(DEPTH * 4);

  logic [31:0] mem [DEPTH];

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        done_q, done_d;
  logic        fetch_fire;
  logic [31:0] rd_word;
  logic [31:0] redirect_aligned;
  logic [31:0] next_seq_pc;

  assign redirect_aligned = redirect_pc & ~32'h3;
  assign next_seq_pc      = fetch_pc_q + 32'd4;
  // Read-first: the combinational read sees the word before this edge's write lands.
  assign rd_word          = mem[fetch_pc_q[AW+1:2]];

  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    done_d       = done_q;
    fetch_fire   = 1'b0;
    if (redirect_valid) begin
      inst_d       = '0;
      inst_pc_d    = '0;
      inst_valid_d = 1'b0;
      fetch_pc_d   = redirect_aligned;
      done_d       = (redirect_aligned >= PC_END);
    end else if (!stall) begin
      if (fetch_pc_q < PC_END) begin
        fetch_fire   = 1'b1;
        inst_d       = rd_word;
        inst_pc_d    = fetch_pc_q;
        inst_valid_d = 1'b1;
        fetch_pc_d   = next_seq_pc;
        done_d       = (next_seq_pc >= PC_END);
      end else begin
        inst_d       = '0;
        inst_pc_d    = '0;
        inst_valid_d = 1'b0;
        done_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q   <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      done_q       <= (RESET_PC >= PC_END);
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      done_q       <= done_d;
    end
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_valid = inst_valid_q;
  assign done       = done_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + (fetch_fire ? 32'd1 : 32'd0);
    perf_stall_d   = perf_stall_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched      = perf_fetched_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: DEPTH=256 main instance plus a DEPTH=4 instance for end-of-memory.
module tb_inst_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, stall = 1'b0, rv = 1'b0, we = 1'b0;
  logic [31:0] rpc = '0, wdata = '0;
  logic [7:0]  waddr = '0;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, done;

  logic        reset4 = 1'b1, stall4 = 1'b0, rv4 = 1'b0, we4 = 1'b0;
  logic [31:0] rpc4 = '0, wdata4 = '0;
  logic [1:0]  waddr4 = '0;
  logic [31:0] inst4, inst_pc4;
  logic        inst_valid4, done4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall_cycles, perf_fetched4, perf_stall_cycles4;
`endif

  inst_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
    .imem_we(we), .imem_waddr(waddr), .imem_wdata(wdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles),
`endif
    .done(done)
  );

  inst_fetch #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset4), .stall(stall4), .redirect_valid(rv4), .redirect_pc(rpc4),
    .imem_we(we4), .imem_waddr(waddr4), .imem_wdata(wdata4),
    .inst(inst4), .inst_pc(inst_pc4), .inst_valid(inst_valid4),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched4), .perf_stall_cycles(perf_stall_cycles4),
`endif
    .done(done4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [65:0] exp;
  logic [31:0] prog [8] = '{32'h00500093, 32'h00308133, 32'h0020A023, 32'h0000A183,
                            32'h00400213, 32'h00128293, 32'h00630333, 32'h007383B3};

  function automatic logic [65:0] obs();
    return {inst, inst_pc, inst_valid, done};
  endfunction

  function automatic logic [65:0] obs4();
    return {inst4, inst_pc4, inst_valid4, done4};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 8'(i); wdata = prog[i];
      step();
    end
    we = 1'b0;
    exp = {32'h0, 32'h0, 1'b0, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL reset_state got=%h exp=%h", obs(), exp); end
    reset = 1'b0;
    step();
    exp = {prog[0], 32'h0, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL first_fetch got=%h exp=%h", obs(), exp); end
  endtask

  task automatic test_stall();
    step();
    exp = {prog[1], 32'h4, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL fetch_pc4 got=%h exp=%h", obs(), exp); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (obs() !== exp) begin n_fail++; $display("FAIL stall_hold%0d got=%h exp=%h", k, obs(), exp); end
    end
    stall = 1'b0;
    for (int k = 2; k < 4; k++) begin
      step();
      exp = {prog[k], 32'(k * 4), 1'b1, 1'b0};
      n_tests++;
      if (obs() !== exp) begin n_fail++; $display("FAIL after_stall%0d got=%h exp=%h", k, obs(), exp); end
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1; rv = 1'b1; rpc = 32'h0000_0012;
    step();
    exp = '0;
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL redir_bubble got=%h exp=%h", obs(), exp); end
    rv = 1'b0; stall = 1'b0;
    step();
    exp = {prog[4], 32'h10, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL redir_target got=%h exp=%h", obs(), exp); end
  endtask

  task automatic test_back_to_back();
    rv = 1'b1; rpc = 32'h8;
    step();
    exp = '0;
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL b2b_bubble1 got=%h exp=%h", obs(), exp); end
    rpc = 32'h1C;
    step();
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL b2b_bubble2 got=%h exp=%h", obs(), exp); end
    rv = 1'b0;
    step();
    exp = {prog[7], 32'h1C, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL b2b_last_wins got=%h exp=%h", obs(), exp); end
  endtask

  task automatic test_read_first();
    rv = 1'b1; rpc = 32'h4;
    step();
    rv = 1'b0; we = 1'b1; waddr = 8'd1; wdata = 32'hDEADBEEF;
    step();
    we = 1'b0;
    exp = {prog[1], 32'h4, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL read_first_old got=%h exp=%h", obs(), exp); end
    rv = 1'b1; rpc = 32'h4;
    step();
    rv = 1'b0;
    step();
    exp = {32'hDEADBEEF, 32'h4, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL read_first_new got=%h exp=%h", obs(), exp); end
  endtask

  task automatic test_reset_mid();
    step();
    exp = {prog[2], 32'h8, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL mid_pc8 got=%h exp=%h", obs(), exp); end
    reset = 1'b1;
    step();
    exp = '0;
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL mid_reset_bubble got=%h exp=%h", obs(), exp); end
`ifdef FETCH_PERF_CNT_EN
    n_tests++;
    if ({perf_fetched, perf_stall_cycles} !== 64'h0) begin
      n_fail++; $display("FAIL perf_reset got=%h/%h exp=0/0", perf_fetched, perf_stall_cycles);
    end
`endif
    reset = 1'b0;
    step();
    exp = {prog[0], 32'h0, 1'b1, 1'b0};
    n_tests++;
    if (obs() !== exp) begin n_fail++; $display("FAIL mid_restart got=%h exp=%h", obs(), exp); end
`ifdef FETCH_PERF_CNT_EN
    n_tests++;
    if ({perf_fetched, perf_stall_cycles} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL perf_count got=%h/%h exp=1/0", perf_fetched, perf_stall_cycles);
    end
`endif
  endtask

  task automatic test_done();
    reset4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      we4 = 1'b1; waddr4 = 2'(i); wdata4 = 32'hA0 + 32'(i);
      step();
    end
    we4 = 1'b0;
    reset4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = {32'hA0 + 32'(i), 32'(i * 4), 1'b1, (i == 3)};
      n_tests++;
      if (obs4() !== exp) begin n_fail++; $display("FAIL d4_fetch%0d got=%h exp=%h", i, obs4(), exp); end
    end
    exp = {32'h0, 32'h0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (obs4() !== exp) begin n_fail++; $display("FAIL d4_done_hold%0d got=%h exp=%h", k, obs4(), exp); end
    end
    rv4 = 1'b1; rpc4 = 32'h20;
    step();
    n_tests++;
    if (obs4() !== exp) begin n_fail++; $display("FAIL d4_redir_oor got=%h exp=%h", obs4(), exp); end
    rpc4 = 32'h0;
    step();
    exp = '0;
    n_tests++;
    if (obs4() !== exp) begin n_fail++; $display("FAIL d4_redir0 got=%h exp=%h", obs4(), exp); end
    rv4 = 1'b0;
    step();
    exp = {32'hA0, 32'h0, 1'b1, 1'b0};
    n_tests++;
    if (obs4() !== exp) begin n_fail++; $display("FAIL d4_refetch got=%h exp=%h", obs4(), exp); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_read_first();
    test_reset_mid();
    test_done();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
